// File: rtl/snn_aer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snn_aer_pkg : shared AER definitions for the spike encoder/decoder pair    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package snn_aer_pkg;

  // AER word layout: {timestamp, address}, address in the low field
  localparam int DROP_CNT_BITS = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  function automatic int addr_bits(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aer_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aer_sync_fifo : first-word fall-through event FIFO with occupancy count    |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module aer_sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BITS = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [PTR_BITS-1:0] r_wr_ptr;
  logic [PTR_BITS-1:0] r_rd_ptr;
  logic [CNT_BITS-1:0] r_count;
  logic                w_push;
  logic                w_pop;

  assign full    = (r_count == CNT_BITS'(DEPTH));
  assign valid   = (r_count != '0);
  assign w_push  = push & ~full;
  assign w_pop   = pop & valid;
  assign count   = r_count;
  // Masked when empty so the head reads zero after reset
  assign rd_data = valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_BITS'(1);
        2'b01:   r_count <= r_count - CNT_BITS'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/spike_aer_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spike_aer_encoder : serialises a spike vector into queued AER events       |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module spike_aer_encoder
  import snn_aer_pkg::*;
#(
  parameter int M          = 4,
  parameter int TS_BITS    = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          time_tick,
  input  logic [M-1:0]                  spikes_in,
  output logic                          aer_valid,
  input  logic                          aer_ready,
  output logic [addr_bits(M)-1:0]       aer_addr,
  output logic [TS_BITS-1:0]            aer_timestamp,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [DROP_CNT_BITS-1:0]      dropped_count,
  output logic                          busy
);

  localparam int ADDR_BITS = addr_bits(M);
  localparam int WORD_BITS = ADDR_BITS + TS_BITS;

  scan_state_e              r_state;
  logic [TS_BITS-1:0]       r_ts;
  logic [TS_BITS-1:0]       r_cap_ts;
  logic [M-1:0]             r_pending;
  logic [DROP_CNT_BITS-1:0] r_drop_cnt;

  logic [ADDR_BITS-1:0]     w_pick;
  logic [M-1:0]             w_pick_oh;
  logic [M-1:0]             w_pending_next;
  logic                     w_push;
  logic                     w_cap_open;
  logic                     w_spike;
  logic                     w_fifo_full;
  logic [WORD_BITS-1:0]     w_rd_data;

  // Downward scan so the lowest set bit is the last assignment
  always_comb begin
    w_pick    = '0;
    w_pick_oh = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_pick       = ADDR_BITS'(i);
        w_pick_oh    = '0;
        w_pick_oh[i] = 1'b1;
      end
    end
  end

  assign w_push         = (r_state == ST_SCAN) && !w_fifo_full;
  assign w_pending_next = w_push ? (r_pending & ~w_pick_oh) : r_pending;
  assign w_cap_open     = (r_state == ST_IDLE) || (w_push && (w_pending_next == '0));
  assign w_spike        = enable && (|spikes_in);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_ts       <= '0;
      r_cap_ts   <= '0;
      r_pending  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (enable && time_tick) r_ts <= r_ts + TS_BITS'(1);

      if (w_spike && w_cap_open) begin
        r_pending <= spikes_in;
        r_cap_ts  <= r_ts;
        r_state   <= ST_SCAN;
      end else begin
        r_pending <= w_pending_next;
        if (r_state == ST_SCAN && w_pending_next == '0) r_state <= ST_IDLE;
        if (w_spike && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + DROP_CNT_BITS'(1);
      end
    end
  end

  aer_sync_fifo #(
    .WIDTH (WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .wr_data ({r_cap_ts, w_pick}),
    .full    (w_fifo_full),
    .pop     (aer_ready),
    .rd_data (w_rd_data),
    .valid   (aer_valid),
    .count   (fifo_count)
  );

  assign aer_addr      = w_rd_data[ADDR_BITS-1:0];
  assign aer_timestamp = w_rd_data[ADDR_BITS +: TS_BITS];
  assign dropped_count = r_drop_cnt;
  assign busy          = (r_state == ST_SCAN);

endmodule
`default_nettype wire

// File: tb/tb_spike_aer_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spike_aer_encoder : directed self-checking bench for spike_aer_encoder  |
// | Revision             : 1.0                                                 |
// +----------------------------------------------------------------------------+
module tb_spike_aer_encoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       time_tick;
  logic [3:0] spikes_in;
  logic       aer_valid;
  logic       aer_ready;
  logic [1:0] aer_addr;
  logic [7:0] aer_timestamp;
  logic [3:0] fifo_count;
  logic [7:0] dropped_count;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  spike_aer_encoder #(.M(4), .TS_BITS(8), .FIFO_DEPTH(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .time_tick     (time_tick),
    .spikes_in     (spikes_in),
    .aer_valid     (aer_valid),
    .aer_ready     (aer_ready),
    .aer_addr      (aer_addr),
    .aer_timestamp (aer_timestamp),
    .fifo_count    (fifo_count),
    .dropped_count (dropped_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [1:0] addr, input logic [7:0] ts);
    check({tag, "_valid"}, 32'(aer_valid), 32'd1);
    check({tag, "_addr"},  32'(aer_addr),  32'(addr));
    check({tag, "_ts"},    32'(aer_timestamp), 32'(ts));
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    time_tick = 1'b0;
    spikes_in = 4'b0000;
    aer_ready = 1'b0;
    #3;
    check("rst_valid", 32'(aer_valid), 32'd0);
    check("rst_addr",  32'(aer_addr), 32'd0);
    check("rst_ts",    32'(aer_timestamp), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_drop",  32'(dropped_count), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    step(); step();
    reset_n = 1'b1;
    enable  = 1'b1;
    step();

    // Advance timestamp to 5, then a two-spike vector with the consumer ready
    time_tick = 1'b1;
    for (int i = 0; i < 5; i++) step();
    time_tick = 1'b0;
    aer_ready = 1'b1;
    spikes_in = 4'b1010;
    step();
    spikes_in = 4'b0000;
    check("t2_busy0", 32'(busy), 32'd1);
    check("t2_valid0", 32'(aer_valid), 32'd0);
    step();
    check_head("t2_ev0", 2'd1, 8'd5);
    check("t2_busy1", 32'(busy), 32'd1);
    step();
    check_head("t2_ev1", 2'd3, 8'd5);
    check("t2_busy2", 32'(busy), 32'd0);
    check("t2_count", 32'(fifo_count), 32'd1);
    step();
    check("t2_empty", 32'(aer_valid), 32'd0);

    // Back-to-back capture on the cycle the last pending bit is pushed
    aer_ready = 1'b0;
    spikes_in = 4'b0110;
    step();
    spikes_in = 4'b0000;
    step();
    spikes_in = 4'b0001;
    step();
    spikes_in = 4'b0000;
    step();
    check("t4_count", 32'(fifo_count), 32'd3);
    check("t4_drop",  32'(dropped_count), 32'd0);
    check("t4_busy",  32'(busy), 32'd0);
    aer_ready = 1'b1;
    check_head("t4_ev0", 2'd1, 8'd5);
    step();
    check_head("t4_ev1", 2'd2, 8'd5);
    step();
    check_head("t4_ev2", 2'd0, 8'd5);
    step();
    check("t4_empty", 32'(aer_valid), 32'd0);

    // Timestamp wrap: spike at ts=255 with a tick in the same cycle
    time_tick = 1'b1;
    for (int i = 0; i < 250; i++) step();
    spikes_in = 4'b0001;
    step();
    time_tick = 1'b0;
    spikes_in = 4'b0000;
    step();
    check_head("t5_ev0", 2'd0, 8'd255);
    step();
    spikes_in = 4'b0100;
    step();
    spikes_in = 4'b0000;
    step();
    check_head("t5_ev1", 2'd2, 8'd0);
    step();

    // Disabled: no capture, no drops, timestamp frozen
    enable    = 1'b0;
    spikes_in = 4'b1111;
    time_tick = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("t6_valid", 32'(aer_valid), 32'd0);
    check("t6_count", 32'(fifo_count), 32'd0);
    check("t6_busy",  32'(busy), 32'd0);
    check("t6_drop",  32'(dropped_count), 32'd0);
    time_tick = 1'b0;
    spikes_in = 4'b0000;
    enable    = 1'b1;
    step();
    spikes_in = 4'b1000;
    step();
    spikes_in = 4'b0000;
    step();
    check_head("t6_ev", 2'd3, 8'd0);
    step();
    check("t6_empty", 32'(aer_valid), 32'd0);

    // Backpressure: ten single spikes, FIFO fills, scanner stalls, one drop
    aer_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      spikes_in = 4'(1 << (i % 4));
      step();
      spikes_in = 4'b0000;
      step();
      step();
    end
    check("t3_count", 32'(fifo_count), 32'd8);
    check("t3_busy",  32'(busy), 32'd1);
    check("t3_drop",  32'(dropped_count), 32'd1);
    check_head("t3_hold", 2'd0, 8'd0);
    step();
    check_head("t3_stable", 2'd0, 8'd0);
    aer_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      check($sformatf("t3_drain%0d_addr", j), 32'(aer_addr), 32'(j % 4));
      check($sformatf("t3_drain%0d_valid", j), 32'(aer_valid), 32'd1);
      step();
    end
    check("t3_empty", 32'(aer_valid), 32'd0);
    check("t3_count_end", 32'(fifo_count), 32'd0);
    check("t3_busy_end", 32'(busy), 32'd0);

    // Reset while scanning with three events queued
    aer_ready = 1'b0;
    spikes_in = 4'b1111;
    step();
    spikes_in = 4'b0000;
    step(); step(); step();
    check("t1_count_pre", 32'(fifo_count), 32'd3);
    check("t1_busy_pre",  32'(busy), 32'd1);
    reset_n = 1'b0;
    #2;
    check("t1_valid", 32'(aer_valid), 32'd0);
    check("t1_addr",  32'(aer_addr), 32'd0);
    check("t1_ts",    32'(aer_timestamp), 32'd0);
    check("t1_count", 32'(fifo_count), 32'd0);
    check("t1_drop",  32'(dropped_count), 32'd0);
    check("t1_busy",  32'(busy), 32'd0);
    step();
    reset_n   = 1'b1;
    aer_ready = 1'b1;
    step(); step(); step();
    check("t1_post_valid", 32'(aer_valid), 32'd0);
    check("t1_post_count", 32'(fifo_count), 32'd0);
    check("t1_post_busy",  32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
